// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-style LCD bus driver.
//   - lcd_state_t : driver FSM states
//   - lcd_wait_t  : selects which post-transfer execution wait applies
//   - default timing constants (clk cycles at 50 MHz)
//   - init ROM contents (bytes and their waits) and the clear/home test
package lcd_pkg;

  localparam int TMR_W   = 20;
  localparam int ROM_LEN = 8;

  localparam int unsigned DEF_T_POWERUP = 750000;
  localparam int unsigned DEF_T_SETUP   = 2;
  localparam int unsigned DEF_T_PULSE   = 12;
  localparam int unsigned DEF_T_HOLD    = 10;
  localparam int unsigned DEF_T_CMD     = 2000;
  localparam int unsigned DEF_T_CLEAR   = 82000;
  localparam int unsigned DEF_T_INIT1   = 205000;
  localparam int unsigned DEF_T_INIT2   = 5000;

  typedef enum logic [2:0] {
    ST_POWERUP,
    ST_LOAD,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_EXEC,
    ST_IDLE
  } lcd_state_t;

  typedef enum logic [1:0] {
    WAIT_CMD,
    WAIT_CLEAR,
    WAIT_INIT1,
    WAIT_INIT2
  } lcd_wait_t;

  // 8-bit interface wake-up (0x30 x3), function set, display off, clear,
  // entry mode, display on.
  function automatic logic [7:0] init_rom_byte(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2: return 8'h30;
      3'd3:             return 8'h38;
      3'd4:             return 8'h08;
      3'd5:             return 8'h01;
      3'd6:             return 8'h06;
      default:          return 8'h0C;
    endcase
  endfunction

  function automatic lcd_wait_t init_rom_wait(input logic [2:0] idx);
    case (idx)
      3'd0:    return WAIT_INIT1;
      3'd1:    return WAIT_INIT2;
      3'd5:    return WAIT_CLEAR;
      default: return WAIT_CMD;
    endcase
  endfunction

  // Clear display (0x01) and return home (0x02/0x03) are the slow commands.
  function automatic lcd_wait_t host_wait(input logic rs, input logic [7:0] data);
    if (!rs && (data == 8'h01 || data == 8'h02 || data == 8'h03))
      return WAIT_CLEAR;
    return WAIT_CMD;
  endfunction

endpackage

// File: rtl/lcd_bus_driver_timer.sv
// lcd_delay_timer: single down-counter shared by all timed FSM states.
//   clk, rst_n : clock and synchronous active-low reset
//   load       : (re)start the count with load_val
//   load_val   : number of cycles until done (>= 1)
//   done       : one-cycle pulse in the last cycle of the loaded interval
// Reset behaves like a load of RST_VAL, so the power-up wait starts
// counting in the first cycle after reset release without an extra load.
module lcd_delay_timer #(
  parameter int          W       = 20,
  parameter int unsigned RST_VAL = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;
  logic         run;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= W'(RST_VAL - 1);
      run <= 1'b1;
    end else if (load) begin
      cnt <= load_val - 1'b1;
      run <= 1'b1;
    end else if (run) begin
      if (cnt == '0) run <= 1'b0;
      else           cnt <= cnt - 1'b1;
    end
  end

  assign done = run && (cnt == '0);

endmodule

// File: rtl/lcd_bus_driver.sv
// lcd_bus_driver: write-only 8-bit HD44780-style LCD bus sequencer.
// Runs the power-up wait and fixed init ROM, then accepts host bytes one
// at a time and strobes them onto the LCD bus with delay-based timing.
//   clk, rst_n            : 50 MHz clock, synchronous active-low reset
//   in_valid/in_ready     : host byte handshake (accepted when both high)
//   in_rs, in_data        : host register select and byte
//   init_done             : init sequence complete (sticky until reset)
//   data_out_en/_on/_rs/_rw, data_out : LCD bus (rw always 0)
//
// state   | meaning
// POWERUP | waiting T_POWERUP after reset, bus idle
// LOAD    | fetch first init ROM byte onto the bus registers
// SETUP   | rs/data driven, en low, T_SETUP cycles
// PULSE   | en high, T_PULSE cycles
// HOLD    | en low, rs/data still held, T_HOLD cycles
// EXEC    | waiting for the LCD to execute the byte
// IDLE    | init done, in_ready high, waiting for a host byte
module lcd_bus_driver
  import lcd_pkg::*;
#(
  parameter int unsigned T_POWERUP = DEF_T_POWERUP,
  parameter int unsigned T_SETUP   = DEF_T_SETUP,
  parameter int unsigned T_PULSE   = DEF_T_PULSE,
  parameter int unsigned T_HOLD    = DEF_T_HOLD,
  parameter int unsigned T_CMD     = DEF_T_CMD,
  parameter int unsigned T_CLEAR   = DEF_T_CLEAR,
  parameter int unsigned T_INIT1   = DEF_T_INIT1,
  parameter int unsigned T_INIT2   = DEF_T_INIT2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_rs,
  input  logic [7:0] in_data,
  output logic       init_done,
  output logic       data_out_en,
  output logic       data_out_on,
  output logic       data_out_rs,
  output logic       data_out_rw,
  output logic [7:0] data_out
);

  lcd_state_t       state;
  logic [2:0]       rom_idx;
  lcd_wait_t        exec_sel;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_done;
  logic             accept;
  logic             last_rom;
  logic [2:0]       next_idx;

  assign accept   = in_valid && in_ready;
  assign last_rom = (rom_idx == 3'(ROM_LEN - 1));
  assign next_idx = rom_idx + 3'd1;

  function automatic logic [TMR_W-1:0] wait_cycles(input lcd_wait_t sel);
    case (sel)
      WAIT_INIT1: return TMR_W'(T_INIT1);
      WAIT_INIT2: return TMR_W'(T_INIT2);
      WAIT_CLEAR: return TMR_W'(T_CLEAR);
      default:    return TMR_W'(T_CMD);
    endcase
  endfunction

  // The timer is loaded on the same edge the FSM changes state, so each
  // timed state lasts exactly its parameter in cycles.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = TMR_W'(T_SETUP);
    case (state)
      ST_LOAD:  tmr_load = 1'b1;
      ST_SETUP: begin
        tmr_load = tmr_done;
        tmr_val  = TMR_W'(T_PULSE);
      end
      ST_PULSE: begin
        tmr_load = tmr_done;
        tmr_val  = TMR_W'(T_HOLD);
      end
      ST_HOLD: begin
        tmr_load = tmr_done;
        tmr_val  = wait_cycles(exec_sel);
      end
      ST_EXEC:  tmr_load = tmr_done && !init_done && !last_rom;
      ST_IDLE:  tmr_load = accept;
      default:  tmr_load = 1'b0;
    endcase
  end

  lcd_delay_timer #(
    .W       (TMR_W),
    .RST_VAL (T_POWERUP)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_POWERUP;
      rom_idx     <= 3'd0;
      exec_sel    <= WAIT_CMD;
      in_ready    <= 1'b0;
      init_done   <= 1'b0;
      data_out_en <= 1'b0;
      data_out_on <= 1'b0;
      data_out_rs <= 1'b0;
      data_out_rw <= 1'b0;
      data_out    <= 8'h00;
    end else begin
      data_out_on <= 1'b1;
      data_out_rw <= 1'b0;
      case (state)
        ST_POWERUP: if (tmr_done) state <= ST_LOAD;
        ST_LOAD: begin
          data_out_rs <= 1'b0;
          data_out    <= init_rom_byte(rom_idx);
          exec_sel    <= init_rom_wait(rom_idx);
          state       <= ST_SETUP;
        end
        ST_SETUP: if (tmr_done) begin
          data_out_en <= 1'b1;
          state       <= ST_PULSE;
        end
        ST_PULSE: if (tmr_done) begin
          data_out_en <= 1'b0;
          state       <= ST_HOLD;
        end
        ST_HOLD: if (tmr_done) state <= ST_EXEC;
        ST_EXEC: if (tmr_done) begin
          // Later init bytes are latched here so the ROM streams without
          // spending a LOAD cycle per byte.
          if (!init_done && !last_rom) begin
            rom_idx     <= next_idx;
            data_out_rs <= 1'b0;
            data_out    <= init_rom_byte(next_idx);
            exec_sel    <= init_rom_wait(next_idx);
            state       <= ST_SETUP;
          end else begin
            init_done <= 1'b1;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        ST_IDLE: if (accept) begin
          in_ready    <= 1'b0;
          data_out_rs <= in_rs;
          data_out    <= in_data;
          exec_sel    <= host_wait(in_rs, in_data);
          state       <= ST_SETUP;
        end
        default: state <= ST_POWERUP;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_bus_driver.sv
module tb_lcd_bus_driver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic       in_rs;
  logic [7:0] in_data;
  logic       init_done;
  logic       data_out_en;
  logic       data_out_on;
  logic       data_out_rs;
  logic       data_out_rw;
  logic [7:0] data_out;

  localparam int P_POWERUP = 100;
  localparam int P_SETUP   = 2;
  localparam int P_PULSE   = 12;
  localparam int P_HOLD    = 10;
  localparam int P_CMD     = 20;
  localparam int P_CLEAR   = 50;
  localparam int P_INIT1   = 40;
  localparam int P_INIT2   = 30;

  lcd_bus_driver #(
    .T_POWERUP (P_POWERUP),
    .T_SETUP   (P_SETUP),
    .T_PULSE   (P_PULSE),
    .T_HOLD    (P_HOLD),
    .T_CMD     (P_CMD),
    .T_CLEAR   (P_CLEAR),
    .T_INIT1   (P_INIT1),
    .T_INIT2   (P_INIT2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_rs       (in_rs),
    .in_data     (in_data),
    .init_done   (init_done),
    .data_out_en (data_out_en),
    .data_out_on (data_out_on),
    .data_out_rs (data_out_rs),
    .data_out_rw (data_out_rw),
    .data_out    (data_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rs;
    logic [7:0] d;
    int         rise;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  bit   abort_flag = 0;

  byte unsigned rom_b[8] = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h08, 8'h01, 8'h06, 8'h0C};
  int           rom_w[8] = '{P_INIT1, P_INIT2, P_CMD, P_CMD, P_CMD, P_CLEAR, P_CMD, P_CMD};

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cyc %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Monitor: every EN pulse must match the next expected transfer.
  initial begin
    logic       en_q = 1'b0;
    int         rise_c = 0;
    logic [7:0] rd = 8'h00;
    logic       rr = 1'b0;
    exp_t       e;
    forever begin
      @(negedge clk);
      check("rw_zero", int'(data_out_rw), 0);
      if (data_out_en && !en_q) begin
        rise_c = cyc;
        rd     = data_out;
        rr     = data_out_rs;
        n_chk++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_en: got pulse data 0x%0h rs %0d, required none at cyc %0d",
                   data_out, data_out_rs, cyc);
        end else begin
          e = sb_q.pop_front();
          check("en_byte", int'(data_out), int'(e.d));
          check("en_rs", int'(data_out_rs), int'(e.rs));
          check("en_rise_cycle", cyc, e.rise);
        end
      end else if (data_out_en && en_q) begin
        check("bus_stable_during_en", int'({data_out_rs, data_out}), int'({rr, rd}));
      end
      if (!data_out_en && en_q) begin
        if (abort_flag) abort_flag = 0;
        else check("en_width", cyc - rise_c, P_PULSE);
      end
      en_q = data_out_en;
    end
  end

  // Called at a negedge after reset has been sampled low.
  task automatic do_init();
    int r, t;
    r = cyc;
    rst_n = 1'b1;
    t = r + 1 + P_POWERUP;
    for (int i = 0; i < 8; i++) begin
      sb_q.push_back('{1'b0, rom_b[i], t + P_SETUP});
      t += P_SETUP + P_PULSE + P_HOLD + rom_w[i];
    end
    @(negedge clk);
    check("on_after_release", int'(data_out_on), 1);
    while (cyc < r + 50) @(negedge clk);
    in_valid = 1'b1;
    in_rs    = 1'b1;
    in_data  = 8'($urandom);
    @(negedge clk);
    in_valid = 1'b0;
    while (!init_done && cyc < r + 700) @(negedge clk);
    check("init_done_cycle", cyc - r, t - r);
    check("ready_after_init", int'(in_ready), 1);
  endtask

  // Called at a negedge where in_ready is high.
  task automatic send(input logic rs, input logic [7:0] d, input bit poke);
    int a, w, gap;
    w   = (!rs && d >= 8'h01 && d <= 8'h03) ? P_CLEAR : P_CMD;
    gap = P_SETUP + P_PULSE + P_HOLD + w + 1;
    a   = cyc;
    in_valid = 1'b1;
    in_rs    = rs;
    in_data  = d;
    sb_q.push_back('{rs, d, a + 1 + P_SETUP});
    @(negedge clk);
    in_valid = 1'b0;
    in_rs    = ~rs;
    in_data  = 8'($urandom);
    check("ready_drop", int'(in_ready), 0);
    while (!in_ready && cyc < a + 200) begin
      in_valid = poke && (cyc == a + P_SETUP + P_PULSE + P_HOLD + 6);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("ready_gap", cyc - a, gap);
    check("idle_data", int'(data_out), int'(d));
    check("idle_rs", int'(data_out_rs), int'(rs));
  endtask

  initial begin
    int a;
    logic       rs;
    logic [7:0] d;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_rs    = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          int'({data_out_en, data_out_on, data_out_rs, data_out_rw, data_out, in_ready, init_done}), 0);
    do_init();

    send(1'b1, 8'h41, 1'b0);
    send(1'b1, 8'h42, 1'b0);
    send(1'b0, 8'h01, 1'b0);
    send(1'b0, 8'h04, 1'b1);
    send(1'b0, 8'h02, 1'b0);
    send(1'b0, 8'h03, 1'b1);
    for (int i = 0; i < 12; i++) begin
      rs = 1'($urandom_range(0, 1));
      d  = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 5)) : 8'($urandom);
      send(rs, d, 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of an EN pulse.
    a = cyc;
    in_valid = 1'b1;
    in_rs    = 1'b1;
    in_data  = 8'h55;
    sb_q.push_back('{1'b1, 8'h55, a + 1 + P_SETUP});
    @(negedge clk);
    in_valid = 1'b0;
    while (cyc < a + 6) @(negedge clk);
    check("en_before_abort", int'(data_out_en), 1);
    abort_flag = 1;
    rst_n = 1'b0;
    @(negedge clk);
    check("en_after_abort", int'(data_out_en), 0);
    check("init_done_after_abort", int'(init_done), 0);
    check("ready_after_abort", int'(in_ready), 0);
    do_init();
    send(1'b1, 8'h5A, 1'b0);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached at cyc %0d, required completion", cyc);
    $fatal(1, "watchdog");
  end

endmodule
